// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, controller state encoding and the chaining-state adder.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ACCUM = 2'd3
  } state_e;

  localparam int         BLOCK_WORDS = 16;
  localparam logic [5:0] LAST_ROUND  = 6'd63;

  localparam logic [31:0] IV0 = 32'h6a09e667;
  localparam logic [31:0] IV1 = 32'hbb67ae85;
  localparam logic [31:0] IV2 = 32'h3c6ef372;
  localparam logic [31:0] IV3 = 32'ha54ff53a;
  localparam logic [31:0] IV4 = 32'h510e527f;
  localparam logic [31:0] IV5 = 32'h9b05688c;
  localparam logic [31:0] IV6 = 32'h1f83d9ab;
  localparam logic [31:0] IV7 = 32'h5be0cd19;

  // {H0..H7}, H0 in the most significant word.
  localparam logic [255:0] SHA256_IV = {IV0, IV1, IV2, IV3, IV4, IV5, IV6, IV7};

  // Word-wise mod 2^32 addition of two packed {A..H} states.
  function automatic logic [255:0] add_state(input logic [255:0] h, input logic [255:0] x);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*32 +: 32] = h[i*32 +: 32] + x[i*32 +: 32];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_word_buf.sv
// 16x32 message block buffer: registered write by load index, combinational read by round.
module sha256_word_buf
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [BLOCK_WORDS];

  // Store one message word per accepted handshake.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sha256_block_ctrl.sv
// Block sequencer for the SHA-256 generator: buffers a 512-bit block, walks the
// generator through 64 rounds, and folds the result into the chaining state.
//
// Message handshake: a word transfers on a rising clk edge where msg_valid and
// msg_ready are both high; msg_word/msg_first/msg_last must be stable while
// msg_valid is high; msg_ready never depends on msg_valid.
module sha256_block_ctrl
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_word,
  input  logic         msg_first,
  input  logic         msg_last,
  output logic [5:0]   gen_counter,
  output logic [31:0]  gen_word,
  output logic [255:0] gen_state_in,
  input  logic         gen_ready,
  input  logic [31:0]  gen_a_outa,
  input  logic [31:0]  gen_a_outb,
  input  logic [223:0] gen_state_out,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy,
  output state_e       dbg_state
);

  state_e         state;
  state_e         state_next;
  logic [3:0]     idx;
  logic           last_blk;
  logic [5:0]     round;
  logic [255:0]   hash;
  logic [255:0]   digest_r;
  logic           digest_valid_r;
  logic [31:0]    buf_rdata;
  logic           hs;
  logic [31:0]    x_a;
  logic [255:0]   sum;

  assign msg_ready = rst_n & (state == ST_LOAD);
  assign hs        = msg_valid & msg_ready;

  sha256_word_buf u_buf (
    .clk   (clk),
    .we    (hs),
    .waddr (idx),
    .wdata (msg_word),
    .raddr (round[3:0]),
    .rdata (buf_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: load 16 words, run 64 rounds, wait for the pipeline, accumulate.
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD:  if (hs && idx == 4'd15) state_next = ST_RUN;
      ST_RUN:   if (round == LAST_ROUND) state_next = ST_DRAIN;
      ST_DRAIN: if (gen_ready) state_next = ST_ACCUM;
      ST_ACCUM: state_next = ST_LOAD;
      default:  state_next = ST_LOAD;
    endcase
  end

  // Load index and the last-block flag captured with word 15.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= 4'd0;
      last_blk <= 1'b0;
    end else if (hs) begin
      idx <= idx + 4'd1;
      if (idx == 4'd15) begin
        last_blk <= msg_last;
      end
    end
  end

  // Round counter: counts in RUN, parks at 63 in DRAIN, zero elsewhere.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      round <= 6'd0;
    end else begin
      case (state)
        ST_RUN:   round <= (round == LAST_ROUND) ? round : round + 6'd1;
        ST_DRAIN: round <= gen_ready ? 6'd0 : round;
        default:  round <= 6'd0;
      endcase
    end
  end

  // Generator feed-forward sum; A arrives in carry-save form.
  assign x_a = gen_a_outa + gen_a_outb;
  assign sum = add_state(hash, {x_a, gen_state_out});

  // Chaining state and digest: IV on a new message, accumulate after each block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hash           <= SHA256_IV;
      digest_r       <= '0;
      digest_valid_r <= 1'b0;
    end else begin
      digest_valid_r <= 1'b0;
      if (hs && idx == 4'd0 && msg_first) begin
        hash <= SHA256_IV;
      end
      if (state == ST_ACCUM) begin
        if (last_blk) begin
          digest_r       <= sum;
          hash           <= SHA256_IV;
          digest_valid_r <= 1'b1;
        end else begin
          hash <= sum;
        end
      end
    end
  end

  assign gen_counter  = round;
  assign gen_word     = (state == ST_RUN && round < 6'(BLOCK_WORDS)) ? buf_rdata : 32'd0;
  assign gen_state_in = hash;
  assign digest       = digest_r;
  assign digest_valid = digest_valid_r;
  assign busy         = (state != ST_LOAD);
  assign dbg_state    = state;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Directed bench for sha256_block_ctrl with a behavioural 3-stage generator model.
module tb_sha256_block_ctrl;
  import sha256_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         msg_valid;
  logic         msg_ready;
  logic [31:0]  msg_word;
  logic         msg_first;
  logic         msg_last;
  logic [5:0]   gen_counter;
  logic [31:0]  gen_word;
  logic [255:0] gen_state_in;
  logic         gen_ready;
  logic [31:0]  gen_a_outa;
  logic [31:0]  gen_a_outb;
  logic [223:0] gen_state_out;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;
  state_e       dbg_state;

  sha256_block_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .msg_valid     (msg_valid),
    .msg_ready     (msg_ready),
    .msg_word      (msg_word),
    .msg_first     (msg_first),
    .msg_last      (msg_last),
    .gen_counter   (gen_counter),
    .gen_word      (gen_word),
    .gen_state_in  (gen_state_in),
    .gen_ready     (gen_ready),
    .gen_a_outa    (gen_a_outa),
    .gen_a_outb    (gen_a_outb),
    .gen_state_out (gen_state_out),
    .digest        (digest),
    .digest_valid  (digest_valid),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference constants ----------------
  localparam logic [255:0] IV_REF   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] DG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'd0};
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'd0, 32'h000001c0};

  logic [31:0] k_tab [64];
  initial begin
    k_tab = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // 64 SHA-256 rounds on {A..H}; returns the final working variables (no feed-forward).
  function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = st;
    for (int i = 0; i < 64; i++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + k_tab[i] + w[i];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a, b, c, d, e, f, g, h};
  endfunction

  // ---------------- generator model ----------------
  // Captures the 16 fed words, answers with gen_ready at t66 and holds it through t67.
  bit           gm_active = 0;
  int           gm_t = 0;
  logic [255:0] gm_st;
  logic [511:0] gm_blk;
  logic [255:0] gm_res;
  logic [31:0]  gm_r;
  logic [5:0]   gm_exp_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      gm_active = 0;
      gen_ready = 1'b0;
    end else begin
      if (!gm_active && busy && gen_counter == 6'd0) begin
        gm_active = 1;
        gm_t      = 0;
        gm_st     = gen_state_in;
        gm_blk    = '0;
      end
      if (gm_active) begin
        if (gm_t < 16) gm_blk[511 - 32*gm_t -: 32] = gen_word;
        gm_exp_cnt = (gm_t <= 63) ? 6'(gm_t) : ((gm_t <= 66) ? 6'd63 : 6'd0);
        if (gm_t == 0 || gm_t == 15 || gm_t == 16 || gm_t == 63 || gm_t == 64 || gm_t == 66 || gm_t == 67)
          check($sformatf("gen_counter_t%0d", gm_t), gen_counter, gm_exp_cnt);
        if (gm_t == 16 || gm_t == 40) check($sformatf("gen_word_t%0d", gm_t), gen_word, 32'd0);
        if (gm_t == 67) begin
          check("state_in_stable", gen_state_in, gm_st);
          check("busy_t67", busy, 1'b1);
        end
        if (gm_t == 66) begin
          gm_res        = compress(gm_st, gm_blk);
          gm_r          = $urandom;
          gen_a_outa    = gm_r;
          gen_a_outb    = gm_res[255:224] - gm_r;
          gen_state_out = gm_res[223:0];
          gen_ready     = 1'b1;
        end
        if (gm_t == 68) begin
          check("busy_t68", busy, 1'b0);
          gen_ready = 1'b0;
          gm_active = 0;
        end
        gm_t++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [255:0] exp_q[$];
  logic [255:0] exp_dg;
  int unsigned  hs_cyc = 0;
  int           dv_count = 0;

  always @(negedge clk) begin
    if (rst_n && digest_valid) begin
      dv_count++;
      if (exp_q.size() == 0) begin
        check("dv_unexpected", digest_valid, 1'b0);
      end else begin
        exp_dg = exp_q.pop_front();
        check("digest", digest, exp_dg);
        check("dv_latency", cyc - hs_cyc, 68);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] w, input logic f, input logic l, input bit gaps);
    int guard;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        msg_valid = 1'b0;
        @(negedge clk);
      end
    end
    msg_valid = 1'b1;
    msg_word  = w;
    msg_first = f;
    msg_last  = l;
    guard = 0;
    while (!msg_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!msg_ready) check("msg_ready_timeout", msg_ready, 1'b1);
    @(negedge clk);
    msg_valid = 1'b0;
  endtask

  // First/last are driven randomly away from words 0 and 15 where they must be ignored.
  task automatic send_block(input logic [511:0] blk, input logic first, input logic last, input bit gaps);
    logic f, l;
    for (int i = 0; i < 16; i++) begin
      f = (i == 0)  ? first : 1'($urandom_range(0, 1));
      l = (i == 15) ? last  : 1'($urandom_range(0, 1));
      send_word(blk[511 - 32*i -: 32], f, l, gaps);
    end
    hs_cyc = cyc;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("idle_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_msg_ready"}, msg_ready, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_gen_counter"}, gen_counter, 6'd0);
    check({tag, "_gen_word"}, gen_word, 32'd0);
    check({tag, "_digest"}, digest, 256'd0);
    check({tag, "_digest_valid"}, digest_valid, 1'b0);
    check({tag, "_state_in"}, gen_state_in, IV_REF);
    check({tag, "_state"}, dbg_state, ST_LOAD);
  endtask

  // ---------------- main sequence ----------------
  int dv_before;

  initial begin
    rst_n         = 1'b0;
    msg_valid     = 1'b0;
    msg_word      = 32'd0;
    msg_first     = 1'b0;
    msg_last      = 1'b0;
    gen_ready     = 1'b0;
    gen_a_outa    = 32'd0;
    gen_a_outb    = 32'd0;
    gen_state_out = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("msg_ready_after_rst", msg_ready, 1'b1);

    // Empty message, single block.
    exp_q.push_back(DG_EMPTY);
    send_block(BLK_EMPTY, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // "abc".
    exp_q.push_back(DG_ABC);
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // Two-block message with random valid gaps: exactly one pulse.
    dv_before = dv_count;
    exp_q.push_back(DG_TWO);
    send_block(BLK_TWO1, 1'b1, 1'b0, 1'b1);
    send_block(BLK_TWO2, 1'b0, 1'b1, 1'b1);
    wait_idle();
    check("two_block_pulses", 32'(dv_count - dv_before), 32'd1);

    // Abort: first block of the long message, then "abc" restarts.
    dv_before = dv_count;
    exp_q.push_back(DG_ABC);
    send_block(BLK_TWO1, 1'b1, 1'b0, 1'b0);
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b0);
    wait_idle();
    check("abort_pulses", 32'(dv_count - dv_before), 32'd1);

    // Reset at t30 of an "abc" block, then a clean "abc".
    dv_before = dv_count;
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    check("busy_before_rst", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    check("msg_ready_after_midrst", msg_ready, 1'b1);
    repeat (100) @(negedge clk);
    check("no_dv_after_rst", 32'(dv_count - dv_before), 32'd0);
    exp_q.push_back(DG_ABC);
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b0);
    wait_idle();
    check("rst_abc_pulses", 32'(dv_count - dv_before), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sha256_block_ctrl.md
# sha256_block_ctrl

Sequencer for the SHA-256 generator datapath. It accepts a padded message as a stream of 32-bit words and buffers each 512-bit block. It then drives the generator's round counter and word input, holds the chaining hash state, and adds the generator's final working variables into that state. When a message's last block finishes, it emits the 256-bit digest. It sits between the message source and the generator, one instance per generator.

## Interface
- No parameters; the block size (16 words) and round count (64) are fixed by SHA-256.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset. It is shared with the generator.
- `msg_valid` in 1: `msg_word` is valid.
- `msg_ready` out 1: controller accepts a word this cycle.
- `msg_word` in 32: message word, big-endian word order.
- `msg_first` in 1: with word index 0, the block starts a new message.
- `msg_last` in 1: with word index 15, the block is the final block of the message.
- `gen_counter` out 6: generator round counter.
- `gen_word` out 32: generator `wordIn`.
- `gen_state_in` out 256: {Ain..Hin}, the chaining state.
- `gen_ready` in 1: generator ready.
- `gen_a_outa`, `gen_a_outb` in 32 each: carry-save halves of A.
- `gen_state_out` in 224: {Bout..Hout}.
- `digest` out 256: {H0..H7} of the last completed message.
- `digest_valid` out 1: one-cycle pulse when `digest` updates.
- `busy` out 1: the controller is not in LOAD.

## Operation
- **States**
  - LOAD: accept words; word index 0..15.
  - RUN: `gen_counter` 0→63.
  - DRAIN: hold 63 until `gen_ready`.
  - ACCUM: update the hash state.
- **LOAD**
  - `msg_ready`=1. Each handshake (`msg_valid & msg_ready`) writes `buf[idx]` and increments `idx`.
  - `msg_first` is sampled only at idx 0. `msg_last` is sampled only at idx 15; both are ignored at other indices.
  - The handshake at idx 15 moves the state to RUN and resets idx to 0.
  - If `msg_first`=1 at idx 0, the hash registers load the IV at that edge. This discards any unfinished message.
- **RUN**
  - `gen_counter` increments by one each cycle, starting at 0.
  - `gen_word` = `buf[gen_counter]` while `gen_counter` < 16, otherwise 0.
  - After the cycle with `gen_counter`=63, the state moves to DRAIN.
- **DRAIN**
  - `gen_counter` holds 63.
  - `gen_ready`=1 moves the state to ACCUM.
- **ACCUM**, for one cycle:
  - Hi ← Hi + Xi mod 2^32, where XA = `gen_a_outa` + `gen_a_outb` and XB..XH come from `gen_state_out`.
  - `gen_counter`=0.
  - If the block is last: `digest` ← the new sum, the hash registers ← IV, and `digest_valid` pulses on the next cycle.
  - Next state is LOAD.
- `gen_ready` is ignored outside DRAIN; it stays high for one stale cycle after ACCUM.
- `gen_state_in` always reflects the hash registers. The registers are stable throughout RUN, DRAIN and ACCUM.
- Outside RUN and DRAIN, `gen_counter`=0 and `gen_word`=0.

## Timing
- **Reset values:** state=LOAD, idx=0, `gen_counter`=0, `gen_word`=0, hash registers=IV, `digest`=0, `digest_valid`=0, `busy`=0. `msg_ready`=0 while `rst_n`=0 and 1 on the first cycle after release.
- **Reset mid-operation:** takes effect at the next edge. Buffered words and the partial message are lost.
- **Per-block cycle sequence**, with t0 = first RUN cycle:
  - t0..t63: `gen_counter` = 0..63.
  - t66: `gen_ready` is first high (the generator's 3-cycle pipeline).
  - t67: ACCUM.
  - t68: LOAD, and `digest_valid` (if last).
- **Throughput:**
  - One block takes at least 84 cycles: 16 load + 68 compute.
  - `busy`=1 from t0 to t67.
  - `msg_valid` gaps during LOAD stall only the load; RUN never stalls.

## Structure
- Shared package `sha256_pkg` holds:
  - the eight IV constants (6a09e667 … 5be0cd19);
  - the state encoding (LOAD, RUN, DRAIN, ACCUM);
  - the constants for block word count (16) and last round (63).
- Sub-module `sha256_word_buf`: a 16×32 register file with a registered write port (idx) and a combinational read port (`gen_counter[3:0]`).

## Test plan
- **Empty message:** one block, word0=80000000, words 1..15 = 0, first=last=1.
  - `digest` = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
  - `digest_valid` pulses exactly 68 cycles after the 16th handshake.
- **"abc":** word0=61626380, word15=00000018, others 0.
  - `digest` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- **Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"**, with `msg_valid` randomly deasserted:
  - Exactly one `digest_valid` pulse.
  - `digest` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- **Abort with `msg_first`:** send block 1 of the two-block message, then the "abc" block with `msg_first`=1.
  - `digest` equals the "abc" digest.
- **Reset mid-computation:** assert `rst_n`=0 at t30 of a block, then send "abc".
  - All outputs return to their reset values.
  - Then exactly the "abc" digest, with no spurious `digest_valid`.
